// File: rtl/riscv_pkg.sv
// Shared definitions for the machine-mode trap controller: CSR addresses,
// cause codes, controller states and the priority-encoder result type.
package riscv_pkg;

  localparam int XLEN = 64;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [5:0] CAUSE_INST_MISALIGN = 6'd0;
  localparam logic [5:0] CAUSE_ILLEGAL       = 6'd2;
  localparam logic [5:0] CAUSE_BREAKPOINT    = 6'd3;
  localparam logic [5:0] CAUSE_LD_MISALIGN   = 6'd4;
  localparam logic [5:0] CAUSE_ST_MISALIGN   = 6'd6;
  localparam logic [5:0] CAUSE_ECALL_M       = 6'd11;

  localparam logic [5:0] CAUSE_MSI = 6'd3;
  localparam logic [5:0] CAUSE_MTI = 6'd7;
  localparam logic [5:0] CAUSE_MEI = 6'd11;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } trap_state_e;

  typedef struct packed {
    logic       valid;
    logic       intr;
    logic [5:0] cause;
  } trap_sel_t;

  // Only address/instruction faults report a value in mtval.
  function automatic logic tval_kept(input trap_sel_t sel);
    return !sel.intr && (sel.cause == CAUSE_INST_MISALIGN || sel.cause == CAUSE_ILLEGAL ||
                         sel.cause == CAUSE_ST_MISALIGN   || sel.cause == CAUSE_LD_MISALIGN);
  endfunction

endpackage

// File: rtl/riscv_trap_prio.sv
// Combinational trap priority encoder: enabled interrupts first, then
// synchronous exceptions in architectural priority order.
module riscv_trap_prio
  import riscv_pkg::*;
(
  input  logic      instmisalign,
  input  logic      illegal,
  input  logic      ebreak,
  input  logic      ecall,
  input  logic      stmisalign,
  input  logic      ldmisalign,
  input  logic      mei_en,
  input  logic      msi_en,
  input  logic      mti_en,
  output trap_sel_t sel
);

  always_comb begin
    sel = '0;
    if (mei_en)            sel = '{valid: 1'b1, intr: 1'b1, cause: CAUSE_MEI};
    else if (msi_en)       sel = '{valid: 1'b1, intr: 1'b1, cause: CAUSE_MSI};
    else if (mti_en)       sel = '{valid: 1'b1, intr: 1'b1, cause: CAUSE_MTI};
    else if (instmisalign) sel = '{valid: 1'b1, intr: 1'b0, cause: CAUSE_INST_MISALIGN};
    else if (illegal)      sel = '{valid: 1'b1, intr: 1'b0, cause: CAUSE_ILLEGAL};
    else if (ebreak)       sel = '{valid: 1'b1, intr: 1'b0, cause: CAUSE_BREAKPOINT};
    else if (ecall)        sel = '{valid: 1'b1, intr: 1'b0, cause: CAUSE_ECALL_M};
    else if (stmisalign)   sel = '{valid: 1'b1, intr: 1'b0, cause: CAUSE_ST_MISALIGN};
    else if (ldmisalign)   sel = '{valid: 1'b1, intr: 1'b0, cause: CAUSE_LD_MISALIGN};
  end

endmodule

// File: rtl/riscv_trap_ctrl.sv
// Machine-mode trap controller with trap CSRs and a RUN/FLUSH sequencer.
// Define RISCV_TRAP_VECTORED_EN to enable vectored interrupt dispatch (mtvec.MODE=1).
module riscv_trap_ctrl
  import riscv_pkg::*;
(
  input  logic            i_riscv_clk,
  input  logic            i_riscv_rst,
  input  logic            i_riscv_trap_valid,
  input  logic [XLEN-1:0] i_riscv_trap_pc,
  input  logic [XLEN-1:0] i_riscv_trap_tval,
  input  logic            i_riscv_trap_instmisalign,
  input  logic            i_riscv_trap_illegal,
  input  logic            i_riscv_trap_ebreak,
  input  logic            i_riscv_trap_ecall,
  input  logic            i_riscv_trap_stmisalign,
  input  logic            i_riscv_trap_ldmisalign,
  input  logic            i_riscv_trap_mret,
  input  logic            i_riscv_trap_mei,
  input  logic            i_riscv_trap_msi,
  input  logic            i_riscv_trap_mti,
  input  logic            i_riscv_trap_csr_we,
  input  logic [11:0]     i_riscv_trap_csr_addr,
  input  logic [XLEN-1:0] i_riscv_trap_csr_wdata,
  output logic [XLEN-1:0] o_riscv_trap_csr_rdata,
  output logic            o_riscv_trap_gototrap,
  output logic            o_riscv_trap_returnfromtrap,
  output logic [XLEN-1:0] o_riscv_trap_tvec,
  output logic [XLEN-1:0] o_riscv_trap_mepc
);

  trap_state_e     state;
  logic            mstatus_mie;
  logic            mstatus_mpie;
  logic            mie_mei;
  logic            mie_msi;
  logic            mie_mti;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mtval_q;

  trap_sel_t       sel;
  logic            active;
  logic            csr_write;
  logic [XLEN-1:0] tvec_base;
  logic [XLEN-1:0] tvec_raw;
  logic [XLEN-1:0] mtvec_wdata;

  riscv_trap_prio u_prio (
    .instmisalign (i_riscv_trap_instmisalign),
    .illegal      (i_riscv_trap_illegal),
    .ebreak       (i_riscv_trap_ebreak),
    .ecall        (i_riscv_trap_ecall),
    .stmisalign   (i_riscv_trap_stmisalign),
    .ldmisalign   (i_riscv_trap_ldmisalign),
    .mei_en       (mstatus_mie & mie_mei & i_riscv_trap_mei),
    .msi_en       (mstatus_mie & mie_msi & i_riscv_trap_msi),
    .mti_en       (mstatus_mie & mie_mti & i_riscv_trap_mti),
    .sel          (sel)
  );

  assign active    = i_riscv_trap_valid & (state == ST_RUN) & ~i_riscv_rst;
  assign o_riscv_trap_gototrap       = active & sel.valid;
  assign o_riscv_trap_returnfromtrap = active & i_riscv_trap_mret & ~sel.valid;
  assign csr_write = i_riscv_trap_csr_we & (state == ST_RUN) & ~o_riscv_trap_gototrap;
  assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};
  assign o_riscv_trap_mepc = mepc_q;

`ifdef RISCV_TRAP_VECTORED_EN
  assign tvec_raw    = (mtvec_q[1:0] == 2'b01 && sel.intr) ?
                       tvec_base + {{(XLEN-8){1'b0}}, sel.cause, 2'b00} : tvec_base;
  assign mtvec_wdata = {i_riscv_trap_csr_wdata[XLEN-1:2], 1'b0,
                        i_riscv_trap_csr_wdata[1:0] == 2'b01};
`else
  assign tvec_raw    = tvec_base;
  assign mtvec_wdata = {i_riscv_trap_csr_wdata[XLEN-1:2], 2'b00};
`endif

  assign o_riscv_trap_tvec = i_riscv_rst ? '0 : tvec_raw;

  always_comb begin
    o_riscv_trap_csr_rdata = '0;
    case (i_riscv_trap_csr_addr)
      CSR_MSTATUS: o_riscv_trap_csr_rdata = {51'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
      CSR_MIE:     o_riscv_trap_csr_rdata = {52'b0, mie_mei, 3'b0, mie_mti, 3'b0, mie_msi, 3'b0};
      CSR_MTVEC:   o_riscv_trap_csr_rdata = mtvec_q;
      CSR_MEPC:    o_riscv_trap_csr_rdata = mepc_q;
      CSR_MCAUSE:  o_riscv_trap_csr_rdata = mcause_q;
      CSR_MTVAL:   o_riscv_trap_csr_rdata = mtval_q;
      CSR_MIP:     o_riscv_trap_csr_rdata = {52'b0, i_riscv_trap_mei, 3'b0, i_riscv_trap_mti, 3'b0,
                                             i_riscv_trap_msi, 3'b0};
      default:     o_riscv_trap_csr_rdata = '0;
    endcase
  end

  // A trap overrides both the CSR port and mret; mret is applied after a CSR write.
  always_ff @(posedge i_riscv_clk or posedge i_riscv_rst) begin
    if (i_riscv_rst) begin
      state        <= ST_RUN;
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_mei      <= 1'b0;
      mie_msi      <= 1'b0;
      mie_mti      <= 1'b0;
      mtvec_q      <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
    end else begin
      case (state)
        ST_RUN:   if (o_riscv_trap_gototrap || o_riscv_trap_returnfromtrap) state <= ST_FLUSH;
        ST_FLUSH: state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
      if (o_riscv_trap_gototrap) begin
        mepc_q       <= {i_riscv_trap_pc[XLEN-1:1], 1'b0};
        mcause_q     <= {sel.intr, 57'b0, sel.cause};
        mtval_q      <= tval_kept(sel) ? i_riscv_trap_tval : '0;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else begin
        if (csr_write) begin
          case (i_riscv_trap_csr_addr)
            CSR_MSTATUS: begin
              mstatus_mie  <= i_riscv_trap_csr_wdata[3];
              mstatus_mpie <= i_riscv_trap_csr_wdata[7];
            end
            CSR_MIE: begin
              mie_msi <= i_riscv_trap_csr_wdata[3];
              mie_mti <= i_riscv_trap_csr_wdata[7];
              mie_mei <= i_riscv_trap_csr_wdata[11];
            end
            CSR_MTVEC:  mtvec_q  <= mtvec_wdata;
            CSR_MEPC:   mepc_q   <= {i_riscv_trap_csr_wdata[XLEN-1:1], 1'b0};
            CSR_MCAUSE: mcause_q <= i_riscv_trap_csr_wdata;
            CSR_MTVAL:  mtval_q  <= i_riscv_trap_csr_wdata;
            default: ;
          endcase
        end
        if (o_riscv_trap_returnfromtrap) begin
          mstatus_mie  <= mstatus_mpie;
          mstatus_mpie <= 1'b1;
        end
      end
    end
  end

endmodule
